// File: rtl/rx_buf_ctrl.sv
// Receive buffer controller: stores UDP payload bytes into a ring of fixed-size
// packet slots in the RX memory and presents committed packets to the host in order.
module rx_buf_ctrl #(
    parameter int SLOTS   = 4,
    parameter int SLOT_AW = 9
) (
    input  logic             RX_CLK,
    input  logic             rst,
    input  logic             rx_udp_data_v,
    input  logic [7:0]       rx_udp_data,
    input  logic             rx_abort,
    input  logic             pkt_rel,
    output logic             mem_we,
    output logic [10:0]      mem_addr,
    output logic [7:0]       mem_din,
    output logic             pkt_avail,
    output logic [1:0]       pkt_slot,
    output logic [SLOT_AW:0] pkt_len,
    output logic             rx_irq,
    output logic [7:0]       drop_cnt
);
    localparam int PW = $clog2(SLOTS);
    localparam int CW = PW + 1;
    localparam int LW = SLOT_AW + 1;
    localparam logic [LW-1:0] SLOT_BYTES = {1'b1, {SLOT_AW{1'b0}}};
    localparam logic [CW-1:0] FULL       = CW'(SLOTS);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } state_t;

    state_t          state_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [LW-1:0]   offset_reg;
    logic [7:0]      drop_cnt_reg;
    logic [LW-1:0]   len_reg [SLOTS];

    logic            mem_we_reg;
    logic [10:0]     mem_addr_reg;
    logic [7:0]      mem_din_reg;
    logic            pkt_avail_reg;
    logic [1:0]      pkt_slot_reg;
    logic [LW-1:0]   pkt_len_reg;
    logic            rx_irq_reg;

    logic            commit;
    logic            rel_ok;
    logic [PW-1:0]   wr_ptr_next;
    logic [PW-1:0]   rd_ptr_next;
    logic [CW-1:0]   count_next;
    logic [LW-1:0]   len_head_next;
    logic [7:0]      drop_cnt_next;

    always_comb begin
        commit        = (state_reg == RECV) && !rx_udp_data_v && !rx_abort;
        rel_ok        = pkt_rel && (count_reg != '0);
        wr_ptr_next   = commit ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
        rd_ptr_next   = rel_ok ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        drop_cnt_next = (drop_cnt_reg == 8'hFF) ? drop_cnt_reg : drop_cnt_reg + 8'd1;
        case ({commit, rel_ok})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
        // The slot being committed this cycle may become the head right away,
        // so its length must bypass the table write.
        if (commit && (rd_ptr_next == wr_ptr_reg)) begin
            len_head_next = offset_reg;
        end else begin
            len_head_next = len_reg[rd_ptr_next];
        end
    end

    // Length table carries no reset; stale entries are never exposed as valid.
    always_ff @(posedge RX_CLK) begin
        if (commit) begin
            len_reg[wr_ptr_reg] <= offset_reg;
        end
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            offset_reg    <= '0;
            drop_cnt_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_din_reg   <= '0;
            pkt_avail_reg <= 1'b0;
            pkt_slot_reg  <= '0;
            pkt_len_reg   <= '0;
            rx_irq_reg    <= 1'b0;
        end else begin
            mem_we_reg    <= 1'b0;
            rx_irq_reg    <= commit;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            pkt_avail_reg <= (count_next != '0);
            pkt_slot_reg  <= 2'(rd_ptr_next);
            pkt_len_reg   <= len_head_next;

            case (state_reg)
                IDLE: begin
                    if (rx_udp_data_v) begin
                        if (count_reg != FULL) begin
                            mem_we_reg   <= 1'b1;
                            mem_addr_reg <= {wr_ptr_reg, SLOT_AW'(0)};
                            mem_din_reg  <= rx_udp_data;
                            offset_reg   <= LW'(1);
                            state_reg    <= RECV;
                        end else begin
                            drop_cnt_reg <= drop_cnt_next;
                            state_reg    <= DROP;
                        end
                    end
                end
                RECV: begin
                    // Abort outranks both the overflow check and the commit.
                    if (rx_abort) begin
                        drop_cnt_reg <= drop_cnt_next;
                        state_reg    <= DROP;
                    end else if (rx_udp_data_v) begin
                        if (offset_reg == SLOT_BYTES) begin
                            drop_cnt_reg <= drop_cnt_next;
                            state_reg    <= DROP;
                        end else begin
                            mem_we_reg   <= 1'b1;
                            mem_addr_reg <= {wr_ptr_reg, offset_reg[SLOT_AW-1:0]};
                            mem_din_reg  <= rx_udp_data;
                            offset_reg   <= offset_reg + LW'(1);
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                DROP: begin
                    if (!rx_udp_data_v) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_din   = mem_din_reg;
    assign pkt_avail = pkt_avail_reg;
    assign pkt_slot  = pkt_slot_reg;
    assign pkt_len   = pkt_len_reg;
    assign rx_irq    = rx_irq_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_rx_buf_ctrl.sv
// Bench for rx_buf_ctrl: directed scenarios plus randomized traffic checked
// against a packet-level model of the slot ring.
module tb_rx_buf_ctrl;
    localparam int SLOTS      = 4;
    localparam int SLOT_AW    = 9;
    localparam int SLOT_BYTES = 1 << SLOT_AW;

    logic             RX_CLK = 1'b0;
    logic             rst = 1'b1;
    logic             rx_udp_data_v = 1'b0;
    logic [7:0]       rx_udp_data = 8'h00;
    logic             rx_abort = 1'b0;
    logic             pkt_rel = 1'b0;
    logic             mem_we;
    logic [10:0]      mem_addr;
    logic [7:0]       mem_din;
    logic             pkt_avail;
    logic [1:0]       pkt_slot;
    logic [SLOT_AW:0] pkt_len;
    logic             rx_irq;
    logic [7:0]       drop_cnt;

    int total = 0;
    int bad   = 0;

    rx_buf_ctrl #(.SLOTS(SLOTS), .SLOT_AW(SLOT_AW)) dut (
        .RX_CLK(RX_CLK), .rst(rst), .rx_udp_data_v(rx_udp_data_v),
        .rx_udp_data(rx_udp_data), .rx_abort(rx_abort), .pkt_rel(pkt_rel),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .pkt_avail(pkt_avail), .pkt_slot(pkt_slot), .pkt_len(pkt_len),
        .rx_irq(rx_irq), .drop_cnt(drop_cnt)
    );

    always #5 RX_CLK = ~RX_CLK;

    // Reference model: a FIFO of committed packets plus the packet being received.
    typedef struct { int slot; int len; } pkt_t;
    pkt_t m_ready[$];
    bit   m_in_run;
    bit   m_storing;
    int   m_fill, m_wslot, m_drops;
    bit   m_we, m_irq;
    int   m_addr, m_din;

    function automatic int exp_slot();
        return (m_ready.size() > 0) ? m_ready[0].slot : m_wslot;
    endfunction

    function automatic int exp_drops();
        return (m_drops > 255) ? 255 : m_drops;
    endfunction

    task automatic model_step(bit v, logic [7:0] d, bit ab, bit rel, bit rs);
        bit   rel_ok;
        pkt_t p;
        m_we  = 1'b0;
        m_irq = 1'b0;
        if (rs) begin
            m_ready.delete();
            m_in_run = 0; m_storing = 0; m_fill = 0; m_wslot = 0; m_drops = 0;
            m_addr = 0; m_din = 0;
            return;
        end
        rel_ok = rel && (m_ready.size() > 0);
        if (!m_in_run) begin
            if (v) begin
                m_in_run = 1;
                if (m_ready.size() < SLOTS) begin
                    m_storing = 1; m_fill = 1;
                    m_we = 1; m_addr = m_wslot * SLOT_BYTES; m_din = int'(d);
                end else begin
                    m_storing = 0; m_drops++;
                end
            end
        end else if (m_storing) begin
            if (ab) begin
                m_storing = 0; m_drops++;
            end else if (v && m_fill < SLOT_BYTES) begin
                m_we = 1; m_addr = m_wslot * SLOT_BYTES + m_fill; m_din = int'(d);
                m_fill++;
            end else if (v) begin
                m_storing = 0; m_drops++;
            end else begin
                p.slot = m_wslot; p.len = m_fill;
                m_ready.push_back(p);
                m_wslot = (m_wslot + 1) % SLOTS;
                m_in_run = 0; m_storing = 0; m_irq = 1;
            end
        end else if (!v) begin
            m_in_run = 0;
        end
        if (rel_ok) void'(m_ready.pop_front());
    endtask

    task automatic tick(bit v, logic [7:0] d, bit ab, bit rel, bit rs);
        rx_udp_data_v = v; rx_udp_data = d; rx_abort = ab; pkt_rel = rel; rst = rs;
        @(posedge RX_CLK);
        model_step(v, d, ab, rel, rs);
        #1;
    endtask

    task automatic do_reset();
        tick(0, 8'h00, 0, 0, 1);
        tick(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
        total++; if (mem_addr !== 11'h000 || mem_din !== 8'h00) begin bad++; $display("FAIL reset_mem_bus got addr=%h din=%h want 000/00", mem_addr, mem_din); end
        total++; if (pkt_avail !== 1'b0 || pkt_slot !== 2'd0 || pkt_len !== '0) begin bad++; $display("FAIL reset_pkt got avail=%b slot=%0d len=%0d want 0/0/0", pkt_avail, pkt_slot, pkt_len); end
        total++; if (rx_irq !== 1'b0 || drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_irq_drop got irq=%b drop=%0d want 0/0", rx_irq, drop_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1, bytes[i], 0, 0, 0);
            total++;
            if (mem_we !== 1'b1 || mem_addr !== 11'(i) || mem_din !== bytes[i]) begin
                bad++; $display("FAIL basic_write[%0d] got we=%b addr=%h din=%h want we=1 addr=%h din=%h", i, mem_we, mem_addr, mem_din, i, bytes[i]);
            end
        end
        tick(0, 8'h00, 0, 0, 0);
        total++; if (rx_irq !== 1'b1) begin bad++; $display("FAIL basic_irq got=%b want=1", rx_irq); end
        total++; if (pkt_avail !== 1'b1 || pkt_slot !== 2'd0 || pkt_len !== 10'd3) begin bad++; $display("FAIL basic_pkt got avail=%b slot=%0d len=%0d want 1/0/3", pkt_avail, pkt_slot, pkt_len); end
        total++; if (mem_we !== 1'b0 || mem_addr !== 11'h002 || mem_din !== 8'h33) begin bad++; $display("FAIL basic_hold got we=%b addr=%h din=%h want 0/002/33", mem_we, mem_addr, mem_din); end
        tick(0, 8'h00, 0, 0, 0);
        total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL basic_irq_one_cycle got=%b want=0", rx_irq); end
        $display("test_basic done");
    endtask

    task automatic test_full_ring();
        do_reset();
        for (int p = 0; p < 4; p++) begin
            tick(1, 8'(p + 1), 0, 0, 0);
            tick(0, 8'h00, 0, 0, 0);
        end
        total++; if (pkt_avail !== 1'b1 || pkt_slot !== 2'd0) begin bad++; $display("FAIL full_head got avail=%b slot=%0d want 1/0", pkt_avail, pkt_slot); end
        tick(1, 8'h55, 0, 0, 0);
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL full_no_write got we=%b want=0", mem_we); end
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL full_drop got=%0d want=1", drop_cnt); end
        tick(0, 8'h00, 0, 0, 0);
        total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL full_no_irq got=%b want=0", rx_irq); end
        tick(0, 8'h00, 0, 1, 0);
        total++; if (pkt_slot !== 2'd1 || pkt_len !== 10'd1) begin bad++; $display("FAIL full_release got slot=%0d len=%0d want 1/1", pkt_slot, pkt_len); end
        tick(1, 8'h66, 0, 0, 0);
        total++; if (mem_we !== 1'b1 || mem_addr !== 11'h000 || mem_din !== 8'h66) begin bad++; $display("FAIL full_reuse got we=%b addr=%h din=%h want 1/000/66", mem_we, mem_addr, mem_din); end
        tick(0, 8'h00, 0, 0, 0);
        total++; if (rx_irq !== 1'b1) begin bad++; $display("FAIL full_reuse_irq got=%b want=1", rx_irq); end
        $display("test_full_ring done");
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        int wrong = 0;
        do_reset();
        for (int i = 0; i <= SLOT_BYTES; i++) begin
            d = 8'(i) ^ 8'hA5;
            tick(1, d, 0, 0, 0);
            if (i < SLOT_BYTES) begin
                total++;
                if (mem_we !== 1'b1 || mem_addr !== 11'(i) || mem_din !== d) begin
                    bad++; wrong++;
                    if (wrong < 4) $display("FAIL ovf_write[%0d] got we=%b addr=%h din=%h want 1/%h/%h", i, mem_we, mem_addr, mem_din, i, d);
                end
            end else begin
                total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL ovf_extra_write got we=%b want=0", mem_we); end
                total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL ovf_drop got=%0d want=1", drop_cnt); end
            end
        end
        tick(0, 8'h00, 0, 0, 0);
        total++; if (rx_irq !== 1'b0 || pkt_avail !== 1'b0) begin bad++; $display("FAIL ovf_no_commit got irq=%b avail=%b want 0/0", rx_irq, pkt_avail); end
        tick(0, 8'h00, 0, 0, 0);
        tick(1, 8'h07, 0, 0, 0);
        total++; if (mem_we !== 1'b1 || mem_addr !== 11'h000) begin bad++; $display("FAIL ovf_next_slot got we=%b addr=%h want 1/000", mem_we, mem_addr); end
        tick(1, 8'h08, 0, 0, 0);
        tick(0, 8'h00, 0, 0, 0);
        total++; if (pkt_avail !== 1'b1 || pkt_slot !== 2'd0 || pkt_len !== 10'd2) begin bad++; $display("FAIL ovf_next_pkt got avail=%b slot=%0d len=%0d want 1/0/2", pkt_avail, pkt_slot, pkt_len); end
        $display("test_overflow done");
    endtask

    task automatic test_abort();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(1, 8'(8'h30 + i), (i == 3), 0, 0);
            total++;
            if (i < 3) begin
                if (mem_we !== 1'b1 || mem_addr !== 11'(i)) begin bad++; $display("FAIL abort_write[%0d] got we=%b addr=%h want 1/%h", i, mem_we, mem_addr, i); end
            end else begin
                if (mem_we !== 1'b0) begin bad++; $display("FAIL abort_no_write[%0d] got we=%b want=0", i, mem_we); end
            end
        end
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL abort_drop got=%0d want=1", drop_cnt); end
        tick(0, 8'h00, 0, 0, 0);
        total++; if (pkt_avail !== 1'b0 || rx_irq !== 1'b0) begin bad++; $display("FAIL abort_no_commit got avail=%b irq=%b want 0/0", pkt_avail, rx_irq); end
        tick(1, 8'hC0, 0, 0, 0);
        total++; if (mem_we !== 1'b1 || mem_addr !== 11'h000 || mem_din !== 8'hC0) begin bad++; $display("FAIL abort_next got we=%b addr=%h din=%h want 1/000/C0", mem_we, mem_addr, mem_din); end
        tick(0, 8'h00, 0, 0, 0);
        total++; if (pkt_avail !== 1'b1 || pkt_slot !== 2'd0 || pkt_len !== 10'd1) begin bad++; $display("FAIL abort_next_pkt got avail=%b slot=%0d len=%0d want 1/0/1", pkt_avail, pkt_slot, pkt_len); end
        $display("test_abort done");
    endtask

    task automatic test_commit_release();
        do_reset();
        tick(1, 8'hA0, 0, 0, 0); tick(1, 8'hA1, 0, 0, 0); tick(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 8'(8'hB0 + i), 0, 0, 0);
        tick(0, 8'h00, 0, 1, 0);
        total++; if (rx_irq !== 1'b1) begin bad++; $display("FAIL cr_irq got=%b want=1", rx_irq); end
        total++; if (pkt_avail !== 1'b1 || pkt_slot !== 2'd1 || pkt_len !== 10'd3) begin bad++; $display("FAIL cr_head got avail=%b slot=%0d len=%0d want 1/1/3", pkt_avail, pkt_slot, pkt_len); end
        tick(0, 8'h00, 0, 0, 0);
        total++; if (rx_irq !== 1'b0 || pkt_avail !== 1'b1) begin bad++; $display("FAIL cr_after got irq=%b avail=%b want 0/1", rx_irq, pkt_avail); end
        tick(0, 8'h00, 0, 1, 0);
        total++; if (pkt_avail !== 1'b0 || pkt_slot !== 2'd2) begin bad++; $display("FAIL cr_count_one got avail=%b slot=%0d want 0/2", pkt_avail, pkt_slot); end
        $display("test_commit_release done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1, 8'h01, 0, 0, 0); tick(0, 8'h00, 0, 0, 0);
        tick(1, 8'h02, 0, 0, 0); tick(1, 8'h03, 0, 0, 0); tick(0, 8'h00, 0, 0, 0);
        tick(1, 8'h04, 0, 0, 0); tick(1, 8'h05, 0, 0, 0);
        tick(1, 8'h06, 0, 0, 1);
        total++; if (mem_we !== 1'b0 || mem_addr !== 11'h000 || mem_din !== 8'h00) begin bad++; $display("FAIL rmid_mem got we=%b addr=%h din=%h want 0/000/00", mem_we, mem_addr, mem_din); end
        total++; if (pkt_avail !== 1'b0 || pkt_slot !== 2'd0 || pkt_len !== '0 || rx_irq !== 1'b0) begin bad++; $display("FAIL rmid_pkt got avail=%b slot=%0d len=%0d irq=%b want 0/0/0/0", pkt_avail, pkt_slot, pkt_len, rx_irq); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rmid_drop got=%0d want=0", drop_cnt); end
        tick(1, 8'hE1, 0, 0, 0);
        total++; if (mem_we !== 1'b1 || mem_addr !== 11'h000 || mem_din !== 8'hE1) begin bad++; $display("FAIL rmid_first got we=%b addr=%h din=%h want 1/000/E1", mem_we, mem_addr, mem_din); end
        for (int i = 0; i < 3; i++) tick(1, 8'(8'hE2 + i), 0, 0, 0);
        tick(0, 8'h00, 0, 0, 0);
        total++; if (pkt_avail !== 1'b1 || pkt_slot !== 2'd0 || pkt_len !== 10'd4 || drop_cnt !== 8'd0) begin bad++; $display("FAIL rmid_commit got avail=%b slot=%0d len=%0d drop=%0d want 1/0/4/0", pkt_avail, pkt_slot, pkt_len, drop_cnt); end
        $display("test_reset_mid done");
    endtask

    task automatic test_drop_saturate();
        do_reset();
        for (int p = 0; p < SLOTS; p++) begin
            tick(1, 8'h10, 0, 0, 0); tick(0, 8'h00, 0, 0, 0);
        end
        for (int n = 1; n <= 260; n++) begin
            tick(1, 8'h20, 0, 0, 0);
            total++;
            if (drop_cnt !== 8'((n > 255) ? 255 : n)) begin bad++; $display("FAIL sat_drop[%0d] got=%0d want=%0d", n, drop_cnt, (n > 255) ? 255 : n); end
            tick(0, 8'h00, 0, 0, 0);
        end
        $display("test_drop_saturate done");
    endtask

    task automatic test_random();
        int run_left = 0;
        int gap_left = 0;
        int pkts = 0;
        bit v, ab, rel, rs;
        logic [SLOT_AW:0] want_len;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0 && gap_left == 0) begin
                run_left = ($urandom_range(0, 15) == 0) ? int'($urandom_range(505, 520)) : int'($urandom_range(1, 12));
                gap_left = $urandom_range(1, 3);
                pkts++;
            end
            if (run_left > 0) begin v = 1; run_left--; end
            else begin v = 0; gap_left--; end
            ab  = ($urandom_range(0, 39) == 0);
            rel = (c < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
            rs  = ($urandom_range(0, 999) == 0);
            tick(v, 8'($urandom), ab, rel, rs);
            total++; if (mem_we !== m_we) begin bad++; $display("FAIL rnd_we c=%0d got=%b want=%b", c, mem_we, m_we); end
            total++; if (mem_addr !== 11'(m_addr) || mem_din !== 8'(m_din)) begin bad++; $display("FAIL rnd_bus c=%0d got addr=%h din=%h want %h/%h", c, mem_addr, mem_din, m_addr, m_din); end
            total++; if (rx_irq !== m_irq) begin bad++; $display("FAIL rnd_irq c=%0d got=%b want=%b", c, rx_irq, m_irq); end
            total++; if (pkt_avail !== (m_ready.size() > 0)) begin bad++; $display("FAIL rnd_avail c=%0d got=%b want=%0d", c, pkt_avail, m_ready.size() > 0); end
            total++; if (pkt_slot !== 2'(exp_slot())) begin bad++; $display("FAIL rnd_slot c=%0d got=%0d want=%0d", c, pkt_slot, exp_slot()); end
            if (m_ready.size() > 0) begin
                want_len = m_ready[0].len;
                total++; if (pkt_len !== want_len) begin bad++; $display("FAIL rnd_len c=%0d got=%0d want=%0d", c, pkt_len, want_len); end
            end
            total++; if (drop_cnt !== 8'(exp_drops())) begin bad++; $display("FAIL rnd_drop c=%0d got=%0d want=%0d", c, drop_cnt, exp_drops()); end
        end
        $display("test_random done: %0d packet runs", pkts);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_ring();
        test_overflow();
        test_abort();
        test_commit_release();
        test_reset_mid();
        test_drop_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_buf_ctrl.md
RX_BUF_CTRL -- requirements
Module: rx_buf_ctrl

Interface
REQ-001 Parameter SLOTS, 4: number of packet slots in RX memory; power of two, 2..4.
REQ-002 Parameter SLOT_AW, 9: log2 of slot size in bytes; SLOT_AW + log2(SLOTS) SHALL equal 11.
REQ-003 RX_CLK  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  in  1  reset; synchronous to RX_CLK, active-high.
REQ-005 rx_udp_data_v  in  1  UDP payload byte valid; contiguous high run = one packet.
REQ-006 rx_udp_data  in  8  UDP payload byte.
REQ-007 rx_abort  in  1  one-cycle pulse; discard packet in progress.
REQ-008 pkt_rel  in  1  one-cycle host pulse; release oldest committed slot.
REQ-009 mem_we  out  1  RX memory write enable.
REQ-010 mem_addr  out  11  RX memory write address = {slot index, byte offset}.
REQ-011 mem_din  out  8  RX memory write data.
REQ-012 pkt_avail  out  1  at least one committed slot pending.
REQ-013 pkt_slot  out  2  index of oldest committed slot; valid when pkt_avail=1.
REQ-014 pkt_len  out  SLOT_AW+1  byte length of oldest committed packet, 1..2^SLOT_AW.
REQ-015 rx_irq  out  1  one-cycle pulse per committed packet.
REQ-016 drop_cnt  out  8  count of dropped packets; saturates at 255.

Function
REQ-017 FSM states: IDLE, RECV, DROP.
REQ-018 Ring state: wr_ptr, rd_ptr (log2(SLOTS) bits, wrap modulo SLOTS), count (0..SLOTS), len table of SLOTS entries.
REQ-019 IDLE, data_v=1, count<SLOTS: write byte to offset 0 of slot wr_ptr, offset<=1, go RECV.
REQ-020 IDLE, data_v=1, count=SLOTS: no write, drop_cnt+1, go DROP.
REQ-021 RECV, data_v=1, offset<2^SLOT_AW: write byte at {wr_ptr, offset}, offset+1.
REQ-022 RECV, data_v=1, offset=2^SLOT_AW (overflow): no write, no commit, drop_cnt+1, go DROP.
REQ-023 RECV, data_v=0: commit: len[wr_ptr]<=offset, wr_ptr+1, count+1, go IDLE.
REQ-024 rx_abort in RECV, including the cycle data_v falls: no commit, drop_cnt+1, go DROP; rx_abort has priority over commit and over overflow.
REQ-025 rx_abort in IDLE or DROP: no effect.
REQ-026 DROP: no writes; on data_v=0 go IDLE; a new packet is never accepted in the cycle data_v is first seen low.
REQ-027 mem_we/mem_addr/mem_din SHALL be registered, valid one cycle after the byte is sampled; mem_we=0 on non-write cycles; mem_addr/mem_din hold their last values when mem_we=0.
REQ-028 rx_irq SHALL pulse exactly one cycle, the cycle after a commit.
REQ-029 pkt_avail, pkt_slot and pkt_len SHALL be registered views of count!=0, rd_ptr and len[rd_ptr]; they update the cycle after a commit or release.
REQ-030 pkt_rel with count>0: rd_ptr+1, count-1; pkt_rel with count=0: ignored.
REQ-031 Commit and valid release in the same cycle: count unchanged, both pointers advance.
REQ-032 A packet SHALL write only into its own slot; committed slots SHALL never be overwritten before release.
REQ-033 drop_cnt SHALL hold at 255, with no wrap.

Reset
REQ-034 With rst=1 at a clock edge, state<=IDLE, wr_ptr=rd_ptr=count=0, offset=0, drop_cnt=0.
REQ-035 Reset SHALL force mem_we=0, mem_addr=0, mem_din=0, pkt_avail=0, pkt_slot=0, pkt_len=0, rx_irq=0.
REQ-036 rst mid-packet SHALL discard the packet without commit or drop count, and SHALL discard all committed slots; the len table need not be cleared.
REQ-037 After reset release, a packet already in progress (data_v=1 on the first cycle) is accepted from that byte on, per REQ-019.

Verification
REQ-038 Bytes 0x11,0x22,0x33, then data_v low -> writes at addr 0x000..0x002; rx_irq pulse; pkt_avail=1, pkt_slot=0, pkt_len=3.
REQ-039 Five 1-byte packets, no release -> slots 0..3 commit; 5th dropped, drop_cnt=1, no write; pkt_rel -> pkt_slot=1; a 6th packet writes at 0x000.
REQ-040 513-byte packet -> bytes 0..511 written at 0x000..0x1FF; no commit, drop_cnt=1, count=0; next packet uses slot 0.
REQ-041 rx_abort on the 4th byte of a 10-byte packet -> no commit, drop_cnt=1; remaining bytes not written; next packet uses slot 0 at 0x000.
REQ-042 count=1, pkt_rel in the same cycle as a commit -> count stays 1; pkt_slot advances to the new packet; rx_irq pulses once.
REQ-043 rst mid-packet with 2 slots committed -> outputs per REQ-035; next packet commits to slot 0 with pkt_len equal to its size.
